buffer_port_ctrl: RTL and testbench

- Storage and handshake side of the team's synchronous buffer: holds the data array, tracks occupancy, and presents valid/ready ports at both ends.
- Ordering is FIFO or FILO, selected by parameter.
- Converts upstream valid/ready writes into qualified pushes and downstream valid/ready reads into qualified pops.
- Full/empty/count status is used by surrounding control logic.

---
 rtl/buffer_pkg.sv | 35 +++
 rtl/buffer_occupancy.sv | 83 ++++++++
 rtl/buffer_port_ctrl.sv | 88 ++++++++
 tb/tb_buffer_port_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buffer_pkg
// Description : Shared types and elaboration helpers for the buffer storage
//               and handshake logic.
// Revision    : 1.0 - initial release
// ============================================================================
package buffer_pkg;

    // Pop ordering of the buffer.
    typedef enum logic {
        FIFO = 1'b0,
        FILO = 1'b1
    } pop_order_e;

    // Order names are exactly four characters, so they fit a 32-bit parameter.
    localparam int c_ORDER_STR_W = 32;

    // True when the order string names a supported ordering.
    function automatic logic pop_order_valid(input logic [c_ORDER_STR_W-1:0] s);
        return (s == "FIFO") || (s == "FILO");
    endfunction

    // Maps the order string onto the enum; unknown strings are rejected separately.
    function automatic pop_order_e pop_order_decode(input logic [c_ORDER_STR_W-1:0] s);
        return (s == "FILO") ? FILO : FIFO;
    endfunction

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : buffer_occupancy
// Description : Occupancy counter, full/empty decode and storage indices for
//               either FIFO (wrapping read/write pointers) or FILO (stack
//               index derived from the count) ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_occupancy
    import buffer_pkg::*;
#(
    parameter int         DEPTH = 8,
    parameter pop_order_e ORDER = FIFO,
    parameter int         CW    = count_width(DEPTH),
    parameter int         IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic [IW-1:0] o_wr_idx,
    output logic [IW-1:0] o_rd_idx
);

    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE  = CW'(1);

    logic [CW-1:0] r_count;

    // Occupancy: up on push only, down on pop only, saturating at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_push && !i_pop && (r_count != c_FULL)) begin
            r_count <= r_count + c_ONE;
        end else if (i_pop && !i_push && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);

    generate
        if (ORDER == FIFO) begin : g_fifo
            localparam logic [IW-1:0] c_LAST = IW'(DEPTH - 1);
            logic [IW-1:0] r_wr;
            logic [IW-1:0] r_rd;

            // Write and read pointers wrap explicitly at DEPTH-1 so any depth works.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr <= '0;
                    r_rd <= '0;
                end else begin
                    if (i_push) begin
                        r_wr <= (r_wr == c_LAST) ? '0 : r_wr + IW'(1);
                    end
                    if (i_pop) begin
                        r_rd <= (r_rd == c_LAST) ? '0 : r_rd + IW'(1);
                    end
                end
            end

            assign o_wr_idx = r_wr;
            assign o_rd_idx = r_rd;
        end else begin : g_filo
            logic [CW-1:0] w_top;

            // The top of stack sits one below the count; a simultaneous
            // push and pop overwrites the top in place.
            assign w_top    = r_count - c_ONE;
            assign o_rd_idx = o_empty ? '0 : IW'(w_top);
            assign o_wr_idx = i_pop ? IW'(w_top) : IW'(r_count);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/buffer_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : buffer_port_ctrl
// Description : Storage array and valid/ready handshake for a synchronous
//               buffer with FIFO or FILO ordering and first-word-fall-through
//               head output.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_port_ctrl
    import buffer_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          DEPTH      = 8,
    parameter logic [31:0] POP_ORDER  = "FIFO"
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [DATA_WIDTH-1:0]           i_in_data,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [DATA_WIDTH-1:0]           o_out_data,
    output logic [count_width(DEPTH)-1:0]   o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam pop_order_e c_ORDER = pop_order_decode(POP_ORDER);
    localparam int         c_CW    = count_width(DEPTH);
    localparam int         c_IW    = $clog2(DEPTH);

    generate
        if (!pop_order_valid(POP_ORDER)) begin : g_bad_order
            $fatal(1, "buffer_port_ctrl: POP_ORDER must be \"FIFO\" or \"FILO\"");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $fatal(1, "buffer_port_ctrl: DEPTH must be at least 2");
        end
    endgenerate

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [c_IW-1:0]       w_wr_idx;
    logic [c_IW-1:0]       w_rd_idx;
    logic [c_CW-1:0]       w_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Ready/valid come only from registered occupancy, so pushes while full
    // and pops while empty are impossible.
    assign o_in_ready  = !w_full;
    assign o_out_valid = !w_empty;
    assign w_push      = i_in_valid && !w_full;
    assign w_pop       = i_out_ready && !w_empty;

    buffer_occupancy #(
        .DEPTH (DEPTH),
        .ORDER (c_ORDER),
        .CW    (c_CW),
        .IW    (c_IW)
    ) u_occupancy (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_wr_idx (w_wr_idx),
        .o_rd_idx (w_rd_idx)
    );

    // Storage array is deliberately left unreset; occupancy masks stale words.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= i_in_data;
        end
    end

    assign o_out_data = r_mem[w_rd_idx];
    assign o_count    = w_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_buffer_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_port_ctrl
// Description : Self-checking bench for buffer_port_ctrl with one FIFO and
//               one FILO instance (DEPTH=4) and a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_port_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       f_in_valid = 1'b0, f_in_ready, f_out_valid, f_out_ready = 1'b0;
    logic       f_full, f_empty;
    logic [7:0] f_in_data = 8'h00, f_out_data;
    logic [2:0] f_count;

    logic       p_in_valid = 1'b0, p_in_ready, p_out_valid, p_out_ready = 1'b0;
    logic       p_full, p_empty;
    logic [7:0] p_in_data = 8'h00, p_out_data;
    logic [2:0] p_count;

    logic [7:0] sb_f[$];
    logic [7:0] sb_p[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    buffer_port_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .POP_ORDER("FIFO")) dut_fifo (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(f_in_valid), .o_in_ready(f_in_ready), .i_in_data(f_in_data),
        .o_out_valid(f_out_valid), .i_out_ready(f_out_ready), .o_out_data(f_out_data),
        .o_count(f_count), .o_full(f_full), .o_empty(f_empty)
    );

    buffer_port_ctrl #(.DATA_WIDTH(8), .DEPTH(4), .POP_ORDER("FILO")) dut_filo (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(p_in_valid), .o_in_ready(p_in_ready), .i_in_data(p_in_data),
        .o_out_valid(p_out_valid), .i_out_ready(p_out_ready), .o_out_data(p_out_data),
        .o_count(p_count), .o_full(p_full), .o_empty(p_empty)
    );

    // One clock of stimulus on the chosen instance. The scoreboard decides
    // from its own occupancy whether a push/pop happens; a pop returns the
    // expected word and the word seen on out_data just before the edge.
    task automatic step(input bit filo, input logic v, input logic [7:0] d, input logic r,
                        output logic popped, output logic [7:0] exp, output logic [7:0] got);
        int sz;
        @(negedge clk);
        if (filo) begin
            p_in_valid = v; p_in_data = d; p_out_ready = r;
        end else begin
            f_in_valid = v; f_in_data = d; f_out_ready = r;
        end
        #1;
        got    = filo ? p_out_data : f_out_data;
        sz     = filo ? sb_p.size() : sb_f.size();
        popped = r && (sz > 0);
        exp    = 8'h00;
        if (popped) exp = filo ? sb_p.pop_back() : sb_f.pop_front();
        if (v && (sz < 4)) begin
            if (filo) sb_p.push_back(d);
            else      sb_f.push_back(d);
        end
        @(posedge clk);
        #1;
        f_in_valid = 1'b0; f_out_ready = 1'b0;
        p_in_valid = 1'b0; p_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", f_count); end
        n_tests++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", f_empty); end
        n_tests++; if (f_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", f_full); end
        n_tests++; if (f_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", f_in_ready); end
        n_tests++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", f_out_valid); end
        n_tests++; if (p_count !== 3'd0) begin n_fail++; $display("FAIL reset_filo_count: got %0d want 0", p_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fifo_fill();
        logic pp; logic [7:0] e, g;
        n_tests++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid_before: got %b want 0", f_out_valid); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'((i + 1) * 17), 1'b0, pp, e, g);
            n_tests++; if (f_count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, f_count, i + 1); end
            n_tests++; if (f_out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid[%0d]: got %b want 1", i, f_out_valid); end
            n_tests++; if (f_out_data !== 8'h11) begin n_fail++; $display("FAIL fill_head[%0d]: got %h want 11", i, f_out_data); end
        end
        n_tests++; if (f_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", f_full); end
        n_tests++; if (f_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", f_in_ready); end
        // Push attempt while full must be held off.
        step(1'b0, 1'b1, 8'h99, 1'b0, pp, e, g);
        n_tests++; if (f_count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count: got %0d want 4", f_count); end
        n_tests++; if (f_out_data !== 8'h11) begin n_fail++; $display("FAIL full_hold_head: got %h want 11", f_out_data); end
    endtask

    task automatic test_fifo_drain();
        logic pp; logic [7:0] e, g;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, pp, e, g);
            if (pp) begin
                n_tests++; if (g !== e) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, g, e); end
            end
        end
        n_tests++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", f_count); end
        n_tests++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", f_empty); end
        n_tests++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", f_out_valid); end
        // Pop attempt while empty must change nothing.
        step(1'b0, 1'b0, 8'h00, 1'b1, pp, e, g);
        n_tests++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d want 0", f_count); end
        n_tests++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL empty_pop_empty: got %b want 1", f_empty); end
    endtask

    task automatic test_fifo_wrap();
        logic pp; logic [7:0] e, g;
        step(1'b0, 1'b1, 8'h20, 1'b0, pp, e, g);
        step(1'b0, 1'b1, 8'h21, 1'b0, pp, e, g);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(8'h22 + i), 1'b1, pp, e, g);
            if (pp) begin
                n_tests++; if (g !== e) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, g, e); end
            end
            n_tests++; if (f_count !== 3'd2) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 2", i, f_count); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, pp, e, g);
            if (pp) begin
                n_tests++; if (g !== e) begin n_fail++; $display("FAIL wrap_tail[%0d]: got %h want %h", i, g, e); end
            end
        end
        n_tests++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", f_empty); end
    endtask

    task automatic test_filo();
        logic pp; logic [7:0] e, g;
        step(1'b1, 1'b1, 8'h0A, 1'b0, pp, e, g);
        step(1'b1, 1'b1, 8'h0B, 1'b0, pp, e, g);
        step(1'b1, 1'b1, 8'h0C, 1'b0, pp, e, g);
        n_tests++; if (p_out_data !== 8'h0C) begin n_fail++; $display("FAIL filo_head: got %h want 0c", p_out_data); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1, pp, e, g);
            if (pp) begin
                n_tests++; if (g !== e) begin n_fail++; $display("FAIL filo_pop[%0d]: got %h want %h", i, g, e); end
            end
        end
        n_tests++; if (p_empty !== 1'b1) begin n_fail++; $display("FAIL filo_empty: got %b want 1", p_empty); end
        step(1'b1, 1'b1, 8'h0A, 1'b0, pp, e, g);
        step(1'b1, 1'b1, 8'h0B, 1'b0, pp, e, g);
        // Simultaneous push and pop at count=2 delivers 0xB and replaces it.
        step(1'b1, 1'b1, 8'h0D, 1'b1, pp, e, g);
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL filo_swap_pop: got %h want %h", g, e); end
        n_tests++; if (p_count !== 3'd2) begin n_fail++; $display("FAIL filo_swap_count: got %0d want 2", p_count); end
        n_tests++; if (p_out_data !== 8'h0D) begin n_fail++; $display("FAIL filo_swap_head: got %h want 0d", p_out_data); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1, pp, e, g);
            if (pp) begin
                n_tests++; if (g !== e) begin n_fail++; $display("FAIL filo_tail[%0d]: got %h want %h", i, g, e); end
            end
        end
        n_tests++; if (p_count !== 3'd0) begin n_fail++; $display("FAIL filo_final_count: got %0d want 0", p_count); end
    endtask

    task automatic test_reset_mid();
        logic pp; logic [7:0] e, g;
        step(1'b0, 1'b1, 8'h61, 1'b0, pp, e, g);
        step(1'b0, 1'b1, 8'h62, 1'b0, pp, e, g);
        step(1'b0, 1'b1, 8'h63, 1'b0, pp, e, g);
        n_tests++; if (f_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 3", f_count); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", f_count); end
        n_tests++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b want 1", f_empty); end
        n_tests++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", f_out_valid); end
        sb_f.delete();
        sb_p.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h55, 1'b0, pp, e, g);
        n_tests++; if (f_out_data !== 8'h55) begin n_fail++; $display("FAIL mid_head: got %h want 55", f_out_data); end
        n_tests++; if (f_count !== 3'd1) begin n_fail++; $display("FAIL mid_post_count: got %0d want 1", f_count); end
        step(1'b0, 1'b0, 8'h00, 1'b1, pp, e, g);
        if (pp) begin
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL mid_pop: got %h want %h", g, e); end
        end
        n_tests++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b want 0", f_out_valid); end
    endtask

    initial begin
        test_reset();
        test_fifo_fill();
        test_fifo_drain();
        test_fifo_wrap();
        test_filo();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
